clear_lines: RTL and testbench
==============================

# clear_lines

Line-clear stage that runs directly after a placed piece has been written into board RAM. While `start` is held, it scans the 10-column board from the bottom row to the top and finds every full row. It removes each full row by shifting all rows above it down one row, then zero-fills row 0. It shares the board RAM port with the piece writer; the top level hands it the port while `start` is high.

## Interface
- `ROWS`, 24, board height in rows; `ROWS*10` must not exceed 256.
- `clk` input 1: system clock, rising-edge.
- `reset` input 1: asynchronous, active-high; forces IDLE and every output to its reset value.
- `start` input 1: level enable; low returns the block to IDLE on the next edge.
- `ram_q` input 6: board RAM read data; 0 means empty cell.
- `ram_addr` output 8: board RAM address, `y*10 + x`; reset value 0.
- `data` output 6: board RAM write data; reset value 0.
- `wren` output 1: board RAM write enable, registered; reset value 0.
- `complete` output 1: high in DONE, registered; reset value 0.
- `lines_cleared` output 3: number of rows removed this run, saturating at 7; reset value 0.

## Operation
- Registers: row `y` (5 bits), column `x` (4 bits), source row `r` (5 bits), latched cell `cell` (6 bits). `ram_addr` is registered, and every address/data update lands on a clock edge.
- Read sequence, 3 states: `*_ADDR` drives `ram_addr`; `*_WAIT` waits for the RAM; `*_CAP` samples `ram_q`.
- Write sequence, 3 states: `WR_SETUP` drives `ram_addr` and `data`; `WR_PULSE` sets `wren` to 1; `WR_END` sets `wren` to 0. `wren` is high for exactly one cycle, with address and data stable for the whole cycle.
- IDLE → SCAN_ADDR when `start` is high. Entry sets `y=ROWS-1`, `x=0`, `lines_cleared=0`.
- SCAN (read cell `(x,y)`):
  - `ram_q==0`: the row is not full. If `y==0` go to DONE; otherwise `y--`, `x=0`, back to SCAN_ADDR. This is the early exit on the first empty cell.
  - `ram_q!=0` and `x<9`: `x++` and read the next cell.
  - `ram_q!=0` and `x==9`: the row is full. Saturating-increment `lines_cleared`, set `r=y`, `x=0`, go to SHIFT.
- SHIFT, for `r>0`: read `(x,r-1)` into `cell`, then write `cell` to `(x,r)`. Advance `x` through 0..9. After `x==9`, `r--` and `x=0`. When `r` reaches 0, go to ZERO.
- ZERO: write 0 to `(x,0)` for `x`=0..9. Then set `x=0` and rescan the same `y`, because new content has dropped into it.
- A full row 0 skips SHIFT and goes straight to ZERO.
- DONE: hold `complete=1`; hold `lines_cleared`; `wren=0`. Leave only when `start` goes low.
- `start` low in any state: on the next edge go to IDLE, `wren=0`, `complete=0`. `lines_cleared` holds. The board may be left partially shifted; the caller must hold `start` until `complete`.
- `reset` asserted mid-operation: IDLE and all outputs at reset values immediately, without waiting for a clock edge.
- Address arithmetic: compute `y*10+x` at 8-bit width; there is no overflow for legal `ROWS`.

## Timing
- RAM read latency: `ram_q` is valid in the `*_CAP` cycle for the address driven since `*_ADDR`.
- Empty board: `complete` rises after edge `3*ROWS+1`, counting the first edge that samples `start` high as edge 1. For `ROWS=24` that is edge 73.
- Scanning a full row costs 30 cycles.
- Clearing row `y>0` costs `60*y` cycles of SHIFT plus 30 cycles of ZERO, followed by the rescan.
- No write occurs outside SHIFT and ZERO.
- `complete` and `wren` are never high in the same cycle.

## Test plan
- Empty board, `ROWS=24`, `start` held high:
  - `complete` rises at edge 73.
  - `lines_cleared=0`.
  - `wren` never asserts.
- Row 23 all 3, cell (4,22)=5, rest empty:
  - Afterwards (4,23)=5 and all other cells of row 23 are 0.
  - Rows 0–22 are all 0.
  - `lines_cleared=1`.
- Rows 22 and 23 full, cell (0,21)=2:
  - Afterwards (0,23)=2 and everything else is 0.
  - `lines_cleared=2`.
  - The same `y=23` is rescanned after the first clear.
- Row 23 full except (9,23)=0:
  - No write occurs.
  - `lines_cleared=0`.
  - `complete` at edge 73 + 27 = 100, because the 10th read of row 23 finds the gap.
- Only row 0 full:
  - Exactly 10 `wren` pulses, all with `data=0` at addresses 0–9.
  - `lines_cleared=1`.
- `reset` asserted during SHIFT while `wren` is high: `wren`, `complete`, `ram_addr` and `lines_cleared` go to 0 before the next edge. Dropping `start` mid-SCAN gives IDLE and `wren=0` after 1 edge.

Source files
------------

// File: rtl/clear_lines.sv
// rtl/clear_lines.sv - line-clear stage: scan board bottom-up, shift full rows down, zero-fill row 0
module clear_lines #(
    parameter int ROWS = 24
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [5:0] i_ram_q,
    output logic [7:0] o_ram_addr,
    output logic [5:0] o_data,
    output logic       o_wren,
    output logic       o_complete,
    output logic [2:0] o_lines_cleared
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [3:0] {
        IDLE,
        SCAN_ADDR,
        SCAN_WAIT,
        SCAN_CAP,
        SH_ADDR,
        SH_WAIT,
        SH_CAP,
        SH_SETUP,
        SH_PULSE,
        SH_END,
        Z_SETUP,
        Z_PULSE,
        Z_END,
        DONE
    } state_t;

    state_t     r_state;
    logic [4:0] r_y;
    logic [3:0] r_x;
    logic [4:0] r_r;
    logic [5:0] r_cell;

    logic [7:0] w_scan_addr;
    logic [7:0] w_src_addr;
    logic [7:0] w_dst_addr;
    logic [4:0] w_r_above;

    // Board addresses: cell under scan, source cell one row up, destination cell in row r.
    assign w_r_above   = r_r - 5'd1;
    assign w_scan_addr = 8'(r_y) * 8'd10 + 8'(r_x);
    assign w_src_addr  = 8'(w_r_above) * 8'd10 + 8'(r_x);
    assign w_dst_addr  = 8'(r_r) * 8'd10 + 8'(r_x);

    // Control FSM: scan rows, shift rows above a full row down, zero row 0, then rescan.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_y             <= 5'd0;
            r_x             <= 4'd0;
            r_r             <= 5'd0;
            r_cell          <= 6'd0;
            o_ram_addr      <= 8'd0;
            o_data          <= 6'd0;
            o_wren          <= 1'b0;
            o_complete      <= 1'b0;
            o_lines_cleared <= 3'd0;
        end else if (!i_start) begin
            // Losing the port mid-run abandons the operation; the count is kept for the caller.
            r_state    <= IDLE;
            o_wren     <= 1'b0;
            o_complete <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_y             <= LAST_ROW;
                    r_x             <= 4'd0;
                    o_lines_cleared <= 3'd0;
                    o_complete      <= 1'b0;
                    r_state         <= SCAN_ADDR;
                end
                SCAN_ADDR: begin
                    o_ram_addr <= w_scan_addr;
                    r_state    <= SCAN_WAIT;
                end
                SCAN_WAIT: r_state <= SCAN_CAP;
                SCAN_CAP: begin
                    if (i_ram_q == 6'd0) begin
                        // First empty cell ends this row's scan early.
                        if (r_y == 5'd0) begin
                            o_complete <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_y     <= r_y - 5'd1;
                            r_x     <= 4'd0;
                            r_state <= SCAN_ADDR;
                        end
                    end else if (r_x != 4'd9) begin
                        r_x     <= r_x + 4'd1;
                        r_state <= SCAN_ADDR;
                    end else begin
                        if (o_lines_cleared != 3'd7)
                            o_lines_cleared <= o_lines_cleared + 3'd1;
                        r_r     <= r_y;
                        r_x     <= 4'd0;
                        r_state <= (r_y == 5'd0) ? Z_SETUP : SH_ADDR;
                    end
                end
                SH_ADDR: begin
                    o_ram_addr <= w_src_addr;
                    r_state    <= SH_WAIT;
                end
                SH_WAIT: r_state <= SH_CAP;
                SH_CAP: begin
                    r_cell  <= i_ram_q;
                    r_state <= SH_SETUP;
                end
                SH_SETUP: begin
                    o_ram_addr <= w_dst_addr;
                    o_data     <= r_cell;
                    r_state    <= SH_PULSE;
                end
                SH_PULSE: begin
                    o_wren  <= 1'b1;
                    r_state <= SH_END;
                end
                SH_END: begin
                    o_wren <= 1'b0;
                    if (r_x == 4'd9) begin
                        r_x     <= 4'd0;
                        r_r     <= w_r_above;
                        r_state <= (r_r == 5'd1) ? Z_SETUP : SH_ADDR;
                    end else begin
                        r_x     <= r_x + 4'd1;
                        r_state <= SH_ADDR;
                    end
                end
                Z_SETUP: begin
                    o_ram_addr <= 8'(r_x);
                    o_data     <= 6'd0;
                    r_state    <= Z_PULSE;
                end
                Z_PULSE: begin
                    o_wren  <= 1'b1;
                    r_state <= Z_END;
                end
                Z_END: begin
                    o_wren <= 1'b0;
                    if (r_x == 4'd9) begin
                        // Rescan the same row: the row above has dropped into it.
                        r_x     <= 4'd0;
                        r_state <= SCAN_ADDR;
                    end else begin
                        r_x     <= r_x + 4'd1;
                        r_state <= Z_SETUP;
                    end
                end
                DONE: begin
                    o_complete <= 1'b1;
                    o_wren     <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clear_lines.sv
// tb/tb_clear_lines.sv - scoreboard bench for clear_lines with a synchronous board RAM model
module tb_clear_lines;

    localparam int ROWS = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] ram_q;
    logic [7:0] ram_addr;
    logic [5:0] data;
    logic       wren;
    logic       complete;
    logic [2:0] lines_cleared;

    always #5 clk = ~clk;

    clear_lines #(.ROWS(ROWS)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_start         (start),
        .i_ram_q         (ram_q),
        .o_ram_addr      (ram_addr),
        .o_data          (data),
        .o_wren          (wren),
        .o_complete      (complete),
        .o_lines_cleared (lines_cleared)
    );

    // Board RAM: one-cycle registered read, write on wren.
    logic [5:0] mem [256];
    always @(posedge clk) begin
        ram_q <= mem[ram_addr];
        if (wren) mem[ram_addr] = data;
    end

    // Run bookkeeping: edges with start high, wren pulses in the run, wren/complete overlap.
    int edges = 0;
    int wcnt  = 0;
    int ovl   = 0;
    always @(posedge clk) begin
        if (wren && complete) ovl++;
        if (!start) begin
            edges = 0;
            wcnt  = 0;
        end else begin
            edges++;
            if (wren) wcnt++;
        end
    end

    typedef struct {
        string name;
        int    lines;
        int    edge_n;
        int    wp;
        bit    chk_board;
        int    nz_n;
        int    a0;
        int    v0;
    } done_t;

    typedef struct {
        string      name;
        bit         c_cmp;
        bit         c_wren;
        bit         c_addr;
        bit         c_lines;
        logic       cmp_v;
        logic       wren_v;
        logic [7:0] addr_v;
        logic [2:0] lines_v;
    } snap_t;

    done_t done_q[$];
    snap_t snap_q[$];
    logic  snap_req = 1'b0;
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Monitor: snapshot checks on request, run-result checks on each complete rise.
    initial begin
        logic  prev_c;
        done_t d;
        snap_t s;
        int    bad;
        int    e;
        prev_c = 1'b0;
        forever begin
            @(negedge clk or posedge snap_req);
            if (snap_req) begin
                if (snap_q.size() == 0) begin
                    chk("snapshot_queue_empty", 0, 1);
                end else begin
                    s = snap_q.pop_front();
                    if (s.c_cmp)   chk({s.name, " complete"}, int'(complete), int'(s.cmp_v));
                    if (s.c_wren)  chk({s.name, " wren"}, int'(wren), int'(s.wren_v));
                    if (s.c_addr)  chk({s.name, " ram_addr"}, int'(ram_addr), int'(s.addr_v));
                    if (s.c_lines) chk({s.name, " lines_cleared"}, int'(lines_cleared), int'(s.lines_v));
                end
            end else begin
                if (complete && !prev_c) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_complete", 1, 0);
                    end else begin
                        d = done_q.pop_front();
                        chk({d.name, " lines_cleared"}, int'(lines_cleared), d.lines);
                        chk({d.name, " complete_edge"}, edges, d.edge_n);
                        chk({d.name, " wren_pulses"}, wcnt, d.wp);
                        chk({d.name, " wren_complete_overlap"}, ovl, 0);
                        if (d.chk_board) begin
                            bad = 0;
                            for (int i = 0; i < ROWS * 10; i++) begin
                                e = (d.nz_n > 0 && i == d.a0) ? d.v0 : 0;
                                if (int'(mem[i]) != e) bad++;
                            end
                            chk({d.name, " board_bad_cells"}, bad, 0);
                        end
                    end
                end
                prev_c = complete;
            end
        end
    end

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) mem[i] = 6'd0;
    endtask

    task automatic fill_row(input int y, input logic [5:0] v);
        for (int x = 0; x < 10; x++) mem[y * 10 + x] = v;
    endtask

    task automatic pulse_snap(input snap_t s);
        snap_q.push_back(s);
        snap_req = 1'b1;
        #1;
        snap_req = 1'b0;
    endtask

    task automatic run_done(input done_t d);
        int k;
        done_q.push_back(d);
        @(negedge clk);
        start = 1'b1;
        k = 0;
        while (!complete && k < 6000) begin
            @(negedge clk);
            k++;
        end
        if (!complete) begin
            void'(done_q.pop_back());
            pulse_snap('{{d.name, " timeout"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0});
        end
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        start = 1'b0;
        clr_mem();
        repeat (2) @(negedge clk);
        pulse_snap('{"reset_state", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0});
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Empty board: 3 edges per row plus the entry edge.
        clr_mem();
        run_done('{"empty", 0, 73, 0, 1'b1, 0, 0, 0});

        // Row 23 full, (4,22)=5: everything drops one row, 23 rows shifted + row 0 zeroed.
        clr_mem();
        fill_row(23, 6'd3);
        mem[224] = 6'd5;
        run_done('{"row23", 1, 1513, 240, 1'b1, 1, 234, 5});

        // Rows 22 and 23 full, (0,21)=2: row 23 cleared twice via rescan.
        clr_mem();
        fill_row(22, 6'd1);
        fill_row(23, 6'd1);
        mem[210] = 6'd2;
        run_done('{"rows22_23", 2, 2956, 480, 1'b1, 1, 230, 2});

        // Row 23 with gap at column 9: ten reads, no clear.
        clr_mem();
        fill_row(23, 6'd3);
        mem[239] = 6'd0;
        run_done('{"gap", 0, 100, 0, 1'b0, 0, 0, 0});

        // Only row 0 full: straight to zero-fill, ten writes of 0.
        clr_mem();
        fill_row(0, 6'd7);
        run_done('{"row0", 1, 133, 10, 1'b1, 0, 0, 0});

        // Drop start mid-scan.
        clr_mem();
        fill_row(23, 6'd3);
        @(negedge clk);
        start = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        pulse_snap('{"start_drop", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0});
        repeat (2) @(negedge clk);

        // Reset while a shift write pulse is high.
        clr_mem();
        fill_row(23, 6'd3);
        @(negedge clk);
        start = 1'b1;
        k = 0;
        while (!wren && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!wren) begin
            pulse_snap('{"reset_wait_wren", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 3'd0});
        end else begin
            #1;
            reset = 1'b1;
            #1;
            pulse_snap('{"async_reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0});
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Fresh run after reset.
        clr_mem();
        run_done('{"empty_again", 0, 73, 0, 1'b1, 0, 0, 0});

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
